// File: rtl/regfile_arbiter.sv
// Arbitrates the single register-file port among sdt, branch, alu and fetch.
// Optional build macro REGFILE_ARB_RR_EN selects round-robin instead of fixed priority.
module regfile_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_i,
    input  logic [NREQ-1:0]   lock_i,
    input  logic [NREQ-1:0]   we_i,
    input  logic [4*NREQ-1:0] reg_sel_i,
    input  logic [32*NREQ-1:0] wdata_i,
    input  logic [NREQ-1:0]   restore_i,
    output logic [NREQ-1:0]   gnt_o,
    output logic [NREQ-1:0]   rvalid_o,
    output logic [31:0]       rdata_o,
    output logic              reg_write_en_o,
    output logic [3:0]        reg_write_reg_o,
    output logic [31:0]       reg_write_value_o,
    output logic              reg_write_restore_from_SPSR_o,
    output logic              reg_read_en_o,
    output logic [3:0]        reg_read_reg_o,
    input  logic [31:0]       reg_read_value_i,
    output logic              busy_o
);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, LOCKED} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            we_q, we_d;
    logic            lock_q, lock_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic            wr_en_q, wr_en_d, wr_rst_q, wr_rst_d, rd_en_q, rd_en_d;
    logic [3:0]      wr_reg_q, wr_reg_d, rd_reg_q, rd_reg_d;
    logic [31:0]     wr_val_q, wr_val_d;

    logic            win_found, take;
    logic [IW-1:0]   win_idx, pick;

`ifdef REGFILE_ARB_RR_EN
    logic [IW-1:0]   ptr_q, ptr_d;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!win_found && req_i[(int'(ptr_q) + k) % NREQ]) begin
                win_found = 1'b1;
                win_idx   = IW'((int'(ptr_q) + k) % NREQ);
            end
        end
    end
`else
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                win_found = 1'b1;
                win_idx   = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        lock_d  = lock_q;
        take    = 1'b0;
        pick    = win_idx;
`ifdef REGFILE_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: if (win_found) begin
                take    = 1'b1;
                state_d = ISSUE;
`ifdef REGFILE_ARB_RR_EN
                ptr_d   = IW'((int'(win_idx) + 1) % NREQ);
`endif
            end
            ISSUE:  state_d = we_q ? (lock_q ? LOCKED : IDLE) : RDWAIT;
            RDWAIT: state_d = lock_q ? LOCKED : IDLE;
            LOCKED: begin
                // Owner keeps the port; other requesters are not even looked at.
                pick = owner_q;
                if (req_i[owner_q]) begin
                    take    = 1'b1;
                    state_d = ISSUE;
                end else if (!lock_i[owner_q]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_d    = '0;
        wr_en_d  = 1'b0;
        wr_reg_d = '0;
        wr_val_d = '0;
        wr_rst_d = 1'b0;
        rd_en_d  = 1'b0;
        rd_reg_d = '0;
        if (take) begin
            owner_d     = pick;
            we_d        = we_i[pick];
            lock_d      = lock_i[pick];
            gnt_d[pick] = 1'b1;
            if (we_i[pick]) begin
                wr_en_d  = 1'b1;
                wr_reg_d = reg_sel_i[4*int'(pick) +: 4];
                wr_val_d = wdata_i[32*int'(pick) +: 32];
                wr_rst_d = restore_i[pick];
            end else begin
                rd_en_d  = 1'b1;
                rd_reg_d = reg_sel_i[4*int'(pick) +: 4];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            we_q     <= 1'b0;
            lock_q   <= 1'b0;
            gnt_q    <= '0;
            wr_en_q  <= 1'b0;
            wr_reg_q <= '0;
            wr_val_q <= '0;
            wr_rst_q <= 1'b0;
            rd_en_q  <= 1'b0;
            rd_reg_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            lock_q   <= lock_d;
            gnt_q    <= gnt_d;
            wr_en_q  <= wr_en_d;
            wr_reg_q <= wr_reg_d;
            wr_val_q <= wr_val_d;
            wr_rst_q <= wr_rst_d;
            rd_en_q  <= rd_en_d;
            rd_reg_q <= rd_reg_d;
        end
    end

`ifdef REGFILE_ARB_RR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ptr_q <= '0;
        else        ptr_q <= ptr_d;
    end
`endif

    assign gnt_o                         = gnt_q;
    assign reg_write_en_o                = wr_en_q;
    assign reg_write_reg_o               = wr_reg_q;
    assign reg_write_value_o             = wr_val_q;
    assign reg_write_restore_from_SPSR_o = wr_rst_q;
    assign reg_read_en_o                 = rd_en_q;
    assign reg_read_reg_o                = rd_reg_q;

    // Read data is passed straight through from the register file in RDWAIT.
    always_comb begin
        rvalid_o = '0;
        rdata_o  = '0;
        if (state_q == RDWAIT) begin
            rvalid_o[owner_q] = 1'b1;
            rdata_o           = reg_read_value_i;
        end
    end

    assign busy_o = (state_q != IDLE) || (|req_i);
endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter: write, read, contention, lock and reset-mid-read.
module tb_regfile_arbiter;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req, lock, we, restore;
    logic [15:0]  reg_sel;
    logic [127:0] wdata;
    logic [3:0]   gnt, rvalid;
    logic [31:0]  rdata;
    logic         wr_en, wr_rst, rd_en, busy;
    logic [3:0]   wr_reg, rd_reg;
    logic [31:0]  wr_val, rd_val;

    int total = 0;
    int bad   = 0;

    regfile_arbiter #(.NREQ(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_i(req), .lock_i(lock), .we_i(we), .reg_sel_i(reg_sel),
        .wdata_i(wdata), .restore_i(restore),
        .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
        .reg_write_en_o(wr_en), .reg_write_reg_o(wr_reg),
        .reg_write_value_o(wr_val), .reg_write_restore_from_SPSR_o(wr_rst),
        .reg_read_en_o(rd_en), .reg_read_reg_o(rd_reg),
        .reg_read_value_i(rd_val), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rf_val(input logic [3:0] r);
        return (r == 4'd5) ? 32'h1234_5678 : (32'hA000_0000 | {28'h0, r});
    endfunction

    // Register file returns data the cycle after a read enable.
    always @(posedge clk) rd_val <= rd_en ? rf_val(rd_reg) : 32'h0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [3:0] r,
                           input logic [31:0] d, input logic lk);
        req[i]            = 1'b1;
        we[i]             = w;
        lock[i]           = lk;
        reg_sel[4*i +: 4] = r;
        wdata[32*i +: 32] = d;
    endtask

    task automatic quiet();
        req = '0; lock = '0; we = '0; restore = '0; reg_sel = '0; wdata = '0;
    endtask

    task automatic single_write(input int i);
        set_req(i, 1'b1, 4'(i), 32'h5555_0000 + 32'(i), 1'b0);
        tick();
        chk("sw_gnt", 32'(gnt), 32'(4'b1 << i));
        req = '0;
        tick();
    endtask

    logic [3:0] exp_ord [4];
    logic [3:0] got_gnt [4];
    int         got_cyc [4];
    int         ng;

    initial begin
        quiet();
        rst_n = 1'b0;
        #12;
        chk("rst_gnt",    32'(gnt), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_wen",    32'(wr_en), 32'h0);
        chk("rst_ren",    32'(rd_en), 32'h0);
        chk("rst_wval",   wr_val, 32'h0);
        chk("rst_busy",   32'(busy), 32'h0);
        rst_n = 1'b1;
        tick();

        // single write from alu
        set_req(2, 1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0);
        tick();
        chk("w_gnt",  32'(gnt), 32'h4);
        chk("w_en",   32'(wr_en), 32'h1);
        chk("w_reg",  32'(wr_reg), 32'h3);
        chk("w_val",  wr_val, 32'hDEAD_BEEF);
        chk("w_ren",  32'(rd_en), 32'h0);
        req = '0;
        tick();
        chk("w_gnt_off", 32'(gnt), 32'h0);
        chk("w_idle",    32'(busy), 32'h0);

        // read from sdt, reg 5
        set_req(0, 1'b0, 4'd5, 32'h0, 1'b0);
        tick();
        chk("r_gnt",  32'(gnt), 32'h1);
        chk("r_ren",  32'(rd_en), 32'h1);
        chk("r_reg",  32'(rd_reg), 32'h5);
        chk("r_wen",  32'(wr_en), 32'h0);
        chk("r_rv_early", 32'(rvalid), 32'h0);
        req = '0;
        tick();
        chk("r_rvalid", 32'(rvalid), 32'h1);
        chk("r_rdata",  rdata, 32'h1234_5678);
        chk("r_gnt_off", 32'(gnt), 32'h0);
        tick();
        chk("r_rv_off", 32'(rvalid), 32'h0);
        chk("r_idle",   32'(busy), 32'h0);

        // grant to branch leaves a round-robin pointer at 2
        single_write(1);

        // contention: all four write, each drops req on its own gnt
        quiet();
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 4'(8 + i), 32'hC0DE_0000 + 32'(i), 1'b0);
`ifdef REGFILE_ARB_RR_EN
        exp_ord = '{4'h4, 4'h8, 4'h1, 4'h2};
`else
        exp_ord = '{4'h1, 4'h2, 4'h4, 4'h8};
`endif
        ng = 0;
        for (int k = 0; k < 4; k++) begin got_gnt[k] = 4'hF; got_cyc[k] = -10; end
        for (int c = 0; c < 20 && ng < 4; c++) begin
            tick();
            if (gnt != 4'h0) begin
                got_gnt[ng] = gnt;
                got_cyc[ng] = c;
                for (int i = 0; i < 4; i++) begin
                    if (gnt[i]) begin
                        chk("c_wreg", 32'(wr_reg), 32'(8 + i));
                        chk("c_wval", wr_val, 32'hC0DE_0000 + 32'(i));
                    end
                end
                ng++;
                req = req & ~gnt;
            end
        end
        for (int k = 0; k < 4; k++) chk("c_order", 32'(got_gnt[k]), 32'(exp_ord[k]));
        for (int k = 1; k < 4; k++) chk("c_gap", 32'(got_cyc[k] - got_cyc[k-1]), 32'd2);
        tick();
        chk("c_idle", 32'(busy), 32'h0);

        // reset in the ISSUE cycle of a read
        quiet();
        set_req(0, 1'b0, 4'd5, 32'h0, 1'b0);
        tick();
        chk("rr_gnt", 32'(gnt), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rr_gnt0",  32'(gnt), 32'h0);
        chk("rr_ren0",  32'(rd_en), 32'h0);
        chk("rr_rreg0", 32'(rd_reg), 32'h0);
        chk("rr_rv0",   32'(rvalid), 32'h0);
        chk("rr_rd0",   rdata, 32'h0);
        req = '0;
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rr_rv_after", 32'(rvalid), 32'h0);
            chk("rr_gnt_after", 32'(gnt), 32'h0);
        end
        chk("rr_idle", 32'(busy), 32'h0);

        // lock: sdt read r1 with lock, alu write pending, sdt write r1 dropping lock
        quiet();
        set_req(0, 1'b0, 4'd1, 32'h0, 1'b1);
        set_req(2, 1'b1, 4'd7, 32'h0BAD_F00D, 1'b0);
        tick();
        chk("l_gnt_rd", 32'(gnt), 32'h1);
        chk("l_ren",    32'(rd_en), 32'h1);
        chk("l_rreg",   32'(rd_reg), 32'h1);
        req[0] = 1'b0;
        tick();
        chk("l_rvalid", 32'(rvalid), 32'h1);
        chk("l_rdata",  rdata, 32'hA000_0001);
        chk("l_gnt_a",  32'(gnt), 32'h0);
        tick();
        chk("l_locked_gnt", 32'(gnt), 32'h0);
        chk("l_locked_wen", 32'(wr_en), 32'h0);
        chk("l_locked_busy", 32'(busy), 32'h1);
        set_req(0, 1'b1, 4'd1, 32'h1111_2222, 1'b0);
        tick();
        chk("l_gnt_wr", 32'(gnt), 32'h1);
        chk("l_wreg",   32'(wr_reg), 32'h1);
        chk("l_wval",   wr_val, 32'h1111_2222);
        req[0] = 1'b0;
        tick();
        chk("l_gap_gnt", 32'(gnt), 32'h0);
        chk("l_gap_wen", 32'(wr_en), 32'h0);
        tick();
        chk("l_alu_gnt", 32'(gnt), 32'h4);
        chk("l_alu_reg", 32'(wr_reg), 32'h7);
        chk("l_alu_val", wr_val, 32'h0BAD_F00D);
        req = '0;
        tick();
        chk("l_idle", 32'(busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_arbiter.md
# regfile_arbiter

Shares the single register-file read/write port between the four CPU execution units that access it: sdt, branch, alu and fetch. Each unit issues one register transaction at a time through a req/gnt handshake. The arbiter serialises these transactions, drives the register-file port from registers, and returns read data. A lock input lets one unit hold the port across a read-modify-write sequence, such as sdt base writeback.

## Interface
Parameters:
- NREQ, 4, number of requesters. Index 0 = sdt, 1 = branch, 2 = alu, 3 = fetch.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req  in  4  per-requester transaction request.
- lock  in  4  per-requester port-hold request.
- we  in  4  per-requester transaction type: 1 = write, 0 = read.
- reg_sel  in  16  per-requester register index; requester i uses bits [4i+3:4i].
- wdata  in  128  per-requester write value; requester i uses bits [32i+31:32i].
- restore  in  4  per-requester restore_from_SPSR flag, applied on writes.
- gnt  out  4  one-hot; pulses for one cycle when the transaction is issued.
- rvalid  out  4  one-hot; pulses for one cycle when read data is valid.
- rdata  out  32  read data; meaningful only while rvalid is high.
- reg_write_en, reg_write_reg[3:0], reg_write_value[31:0], reg_write_restore_from_SPSR  out  register-file write port.
- reg_read_en, reg_read_reg[3:0]  out  register-file read port.
- reg_read_value  in  32  register-file read data, valid in the cycle after reg_read_en.
- busy  out  1  asserted when state != IDLE or |req; feeds the CPU all_busy term.

## Operation
- States: IDLE, ISSUE, RDWAIT, LOCKED.
- IDLE:
  - If any req bit is set, pick a winner and latch its index, we, reg_sel, wdata, restore and lock. Go to ISSUE.
- ISSUE:
  - gnt[w]=1.
  - Registered port outputs are active this cycle: reg_write_* when we=1, reg_read_* when we=0.
  - For a write, go to LOCKED if the latched lock is set, otherwise go to IDLE.
  - For a read, go to RDWAIT.
- RDWAIT:
  - rdata = reg_read_value (combinational pass-through) and rvalid[w]=1.
  - Go to LOCKED if the latched lock is set, otherwise go to IDLE.
- LOCKED:
  - Only the owner is considered; all other req bits are ignored.
  - If req[owner]=1, latch its fields, re-sample lock and go to ISSUE.
  - Else if lock[owner]=0, go to IDLE.
  - Else stay in LOCKED.
- Winner selection: fixed priority, lowest index wins (see Configuration).
- Requester rules:
  - Fields must be held stable while req is high, until gnt is seen.
  - req must be deasserted, or changed to a new request, in the cycle after gnt.
- A request is either a write or a read, never both.
- Register index 15 is passed through unmodified; PC semantics belong to the register file.
- Reset values: state IDLE; gnt, rvalid, rdata, all reg_* enables, reg_*_reg, reg_write_value and restore are 0; owner is 0; RR pointer is 0.
- Reset mid-transaction: the transaction is abandoned and no gnt or rvalid is produced afterwards.

## Timing
- Request seen in IDLE in cycle N gives gnt and port enable in cycle N+1.
- For reads, rvalid and rdata appear in cycle N+2.
- Throughput, unlocked: one write every 2 cycles, one read every 3 cycles.
- Throughput, locked (owner re-requesting in LOCKED): same per-transaction latency, with no arbitration loss to other requesters.
- Simultaneous requests are resolved in one cycle; losers keep req high and wait.
- lock takes effect only when latched in IDLE or LOCKED. Asserting lock while already in ISSUE has no effect until the next latch.

## Configuration
- REGFILE_ARB_RR_EN
  - Defined: round-robin. The search starts at the pointer, and after each grant made from IDLE the pointer becomes (winner+1) mod 4.
  - Undefined: fixed priority, sdt > branch > alu > fetch, and the pointer logic is absent.
  - LOCKED behaviour is identical in both builds.

## Test plan
- Single write: req[2]=1, we[2]=1, reg 3, value 0xDEADBEEF.
  - Required: gnt[2] one cycle later, with reg_write_en=1, reg_write_reg=3 and reg_write_value=0xDEADBEEF in the same cycle.
  - Required: back in IDLE the following cycle.
- Read: reg_read_value model returns 0x12345678 for reg 5; requester 0 reads reg 5.
  - Required: reg_read_en and gnt[0] in cycle N+1; rvalid[0] and rdata=0x12345678 in cycle N+2.
- Contention: req=4'b1111, all writes, held until each requester's own gnt.
  - Fixed-priority build: gnt order 0,1,2,3, with grants 2 cycles apart.
  - REGFILE_ARB_RR_EN build starting from pointer 2: gnt order 2,3,0,1.
- Lock: sdt reads r1 with lock=1 while alu requests a write, then sdt writes r1 and drops lock.
  - Required: the alu gnt appears only after sdt's write is issued and LOCKED has exited.
  - Required: no alu port activity in between.
- Reset mid-read: assert rst_n=0 in the ISSUE cycle of a read.
  - Required: all outputs are 0 immediately, no rvalid afterwards, and state is IDLE after reset release.
